// File: rtl/proc_control.sv
// proc_control: fetch/decode FSM and instruction register for the 16-bit simple processor
//   clk, resetn        : clock, asynchronous active-low reset
//   run                : permits fetch of a new instruction (sampled in T0 only)
//   din                : synchronous memory read data, captured into ir in T2
//   ir                 : instruction register (also bus-mux input 8)
//   sel                : bus-mux select (0-7 r0-r7, 8 IR immediate, 9 G)
//   r_in               : one-hot register load enables (r7 is the PC)
//   a_in, g_in, alu_op : ALU operand-A load, result load, operation (00 add, 01 sub, 10 and)
//   addr_in, dout_in   : memory address / data-out register loads
//   w_d                : memory write strobe
//   pc_incr            : increment r7
//   done               : pulse in the last cycle of an instruction
module proc_control #(
  parameter logic [2:0] OP_MV  = 3'b000,
  parameter logic [2:0] OP_MVT = 3'b001,
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_SUB = 3'b011,
  parameter logic [2:0] OP_AND = 3'b100,
  parameter logic [2:0] OP_ST  = 3'b101
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic [15:0] din,
  output logic [15:0] ir,
  output logic [3:0]  sel,
  output logic [7:0]  r_in,
  output logic        a_in,
  output logic        g_in,
  output logic [1:0]  alu_op,
  output logic        addr_in,
  output logic        dout_in,
  output logic        w_d,
  output logic        pc_incr,
  output logic        done
);
  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} state_t;
  state_t      r_state;
  logic [15:0] r_ir;
  logic [2:0]  w_op, w_rx, w_ry;
  logic        w_imm, w_alu, w_st, w_short, w_fetch;
  logic [7:0]  w_rx_hot;
  logic [3:0]  w_opb;
  assign ir       = r_ir;
  assign w_op     = r_ir[15:13];
  assign w_imm    = r_ir[12];
  assign w_rx     = r_ir[11:9];
  assign w_ry     = r_ir[2:0];
  assign w_alu    = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND);
  assign w_st     = (w_op == OP_ST);
  assign w_short  = !(w_alu || w_st);
  assign w_rx_hot = 8'b1 << w_rx;
  assign w_opb    = w_imm ? 4'd8 : {1'b0, w_ry};
  // Fetch outputs are qualified by resetn so a high run cannot leak through while reset is held.
  assign w_fetch  = run && resetn;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        T0:      r_state <= run ? T1 : T0;
        T1:      r_state <= T2;
        T2: begin
          r_ir    <= din;
          r_state <= T3;
        end
        T3:      r_state <= w_short ? T0 : T4;
        T4:      r_state <= T5;
        default: r_state <= T0;
      endcase
    end
  end
  always_comb begin
    sel     = '0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    alu_op  = 2'b00;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_d     = 1'b0;
    pc_incr = 1'b0;
    done    = 1'b0;
    case (r_state)
      T0: begin
        sel     = w_fetch ? 4'd7 : 4'd0;
        addr_in = w_fetch;
        pc_incr = w_fetch;
      end
      T3: begin
        sel     = (w_op == OP_MV) ? w_opb : (w_op == OP_MVT) ? 4'd8 : (w_alu || w_st) ? {1'b0, w_rx} : 4'd0;
        r_in    = (w_op == OP_MV || w_op == OP_MVT) ? w_rx_hot : 8'h00;
        a_in    = w_alu;
        dout_in = w_st;
        done    = w_short;
      end
      T4: begin
        sel     = w_alu ? w_opb : w_st ? {1'b0, w_ry} : 4'd0;
        g_in    = w_alu;
        alu_op  = !w_alu ? 2'b00 : (w_op == OP_SUB) ? 2'b01 : (w_op == OP_AND) ? 2'b10 : 2'b00;
        addr_in = w_st;
      end
      T5: begin
        sel  = w_alu ? 4'd9 : 4'd0;
        r_in = w_alu ? w_rx_hot : 8'h00;
        w_d  = w_st;
        done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: directed self-checking bench for proc_control
module tb_proc_control;
  logic        clk = 1'b0;
  logic        resetn, run;
  logic [15:0] din, ir;
  logic [3:0]  sel;
  logic [7:0]  r_in;
  logic        a_in, g_in, addr_in, dout_in, w_d, pc_incr, done;
  logic [1:0]  alu_op;
  int          n_cmp = 0;
  int          n_bad = 0;
  proc_control dut (
    .clk(clk), .resetn(resetn), .run(run), .din(din), .ir(ir), .sel(sel), .r_in(r_in),
    .a_in(a_in), .g_in(g_in), .alu_op(alu_op), .addr_in(addr_in), .dout_in(dout_in),
    .w_d(w_d), .pc_incr(pc_incr), .done(done)
  );
  always #5 clk = ~clk;
  // flag order: a_in g_in alu_op[1:0] addr_in dout_in w_d pc_incr done
  logic [20:0] ctl;
  assign ctl = {sel, r_in, a_in, g_in, alu_op, addr_in, dout_in, w_d, pc_incr, done};
  function automatic logic [20:0] c(input logic [3:0] s, input logic [7:0] r, input logic [8:0] f);
    return {s, r, f};
  endfunction
  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  localparam logic [20:0] IDLE = 21'h0;
  logic [20:0] f0;
  task automatic fetch(input logic [15:0] w);
    check("t0_fetch", ctl, f0);
    cyc();
    check("t1_idle", ctl, IDLE);
    din = w;
    cyc();
    check("t2_idle", ctl, IDLE);
    cyc();
    check("ir_load", {5'b0, ir}, {5'b0, w});
  endtask
  task automatic alu_op3(input string tag, input logic [15:0] w, input logic [20:0] e3,
                         input logic [20:0] e4, input logic [20:0] e5);
    fetch(w);
    check({tag, "_t3"}, ctl, e3);
    cyc();
    check({tag, "_t4"}, ctl, e4);
    cyc();
    check({tag, "_t5"}, ctl, e5);
    cyc();
  endtask
  initial begin
    f0 = c(4'd7, 8'h00, 9'b000010010);
    resetn = 1'b0;
    run    = 1'b1;
    din    = 16'hFFFF;
    #1;
    check("rst_ctl", ctl, IDLE);
    check("rst_ir", {5'b0, ir}, 21'h0);
    cyc();
    cyc();
    check("rst_hold_ctl", ctl, IDLE);
    run    = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_run0", ctl, IDLE);
    end
    check("idle_ir", {5'b0, ir}, 21'h0);
    run = 1'b1;
    #1;
    fetch(16'h11A5);
    check("mv_imm_t3", ctl, c(4'd8, 8'h01, 9'b000000001));
    cyc();
    alu_op3("add_reg", 16'h4202, c(4'd1, 8'h00, 9'b100000000), c(4'd2, 8'h00, 9'b010000000),
            c(4'd9, 8'h02, 9'b000000001));
    alu_op3("sub_imm", 16'h7605, c(4'd3, 8'h00, 9'b100000000), c(4'd8, 8'h00, 9'b010100000),
            c(4'd9, 8'h08, 9'b000000001));
    alu_op3("st", 16'hA804, c(4'd4, 8'h00, 9'b000001000), c(4'd4, 8'h00, 9'b000010000),
            c(4'd0, 8'h00, 9'b000000101));
    alu_op3("and_jmp", 16'h9E12, c(4'd7, 8'h00, 9'b100000000), c(4'd8, 8'h00, 9'b011000000),
            c(4'd9, 8'h80, 9'b000000001));
    fetch(16'h2A34);
    check("mvt_t3", ctl, c(4'd8, 8'h20, 9'b000000001));
    cyc();
    fetch(16'h0C03);
    check("mv_reg_t3", ctl, c(4'd3, 8'h40, 9'b000000001));
    cyc();
    fetch(16'hC000);
    check("nop_t3", ctl, c(4'd0, 8'h00, 9'b000000001));
    cyc();
    fetch(16'h4202);
    check("drop_t3", ctl, c(4'd1, 8'h00, 9'b100000000));
    run = 1'b0;
    din = 16'hFFFF;
    cyc();
    check("drop_t4", ctl, c(4'd2, 8'h00, 9'b010000000));
    cyc();
    check("drop_t5", ctl, c(4'd9, 8'h02, 9'b000000001));
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("drop_hold", ctl, IDLE);
    end
    check("drop_ir", {5'b0, ir}, {5'b0, 16'h4202});
    run = 1'b1;
    #1;
    fetch(16'h4202);
    cyc();
    check("rst_mid_t4", ctl, c(4'd2, 8'h00, 9'b010000000));
    resetn = 1'b0;
    #1;
    check("rst_async_ctl", ctl, IDLE);
    check("rst_async_ir", {5'b0, ir}, 21'h0);
    cyc();
    check("rst_mid_hold", ctl, IDLE);
    run = 1'b0;
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("post_rst_idle", ctl, IDLE);
    end
    run = 1'b1;
    #1;
    check("post_rst_fetch", ctl, f0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
